alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencer that runs 32-bit and 64-bit add/sub/logic operations through an external 32-bit ALU,
// taking one ALU pass for 32-bit ops and two (low half, then high half with carry chain) for 64-bit ops.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [31:0] req_imm,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_y,
    output logic        rsp_c,
    output logic        rsp_v,
    output logic        rsp_n,
    output logic        rsp_z,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_imm,
    output logic        alu_src,
    output logic        alu_bsel,
    output logic        alu_cisel,
    output logic        alu_loa,
    output logic        alu_logop,
    input  logic [31:0] alu_y,
    input  logic        alu_c,
    input  logic        alu_v,
    input  logic        alu_n,
    input  logic        alu_z,
    output logic [15:0] op_count
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready=1
    // LO    | ALU runs the 32-bit op or the low half of a 64-bit op
    // HI    | ALU runs the high half of a 64-bit op, carry chained from LO
    // RESP  | result held on rsp_* until the consumer accepts it
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    localparam logic [2:0] OP_SUB32  = 3'b001;
    localparam logic [2:0] OP_AND32  = 3'b010;
    localparam logic [2:0] OP_OR32   = 3'b011;
    localparam logic [2:0] OP_ADDI32 = 3'b100;
    localparam logic [2:0] OP_SUBI32 = 3'b101;
    localparam logic [2:0] OP_ADD64  = 3'b110;
    localparam logic [2:0] OP_SUB64  = 3'b111;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic [31:0] imm_q;
    logic        is_sub;
    logic        is_64;

    assign is_sub = (op_q == OP_SUB32) || (op_q == OP_SUBI32) || (op_q == OP_SUB64);
    assign is_64  = (op_q == OP_ADD64) || (op_q == OP_SUB64);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            rsp_y    <= '0;
            rsp_c    <= 1'b0;
            rsp_v    <= 1'b0;
            rsp_n    <= 1'b0;
            rsp_z    <= 1'b0;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        a_q   <= req_a;
                        b_q   <= req_b;
                        imm_q <= req_imm;
                    end
                end
                LO: begin
                    // rsp_c doubles as the carry fed into the HI pass
                    rsp_y <= {32'h0, alu_y};
                    rsp_c <= alu_c;
                    rsp_v <= alu_v;
                    rsp_n <= alu_n;
                    rsp_z <= alu_z;
                end
                HI: begin
                    rsp_y[63:32] <= alu_y;
                    rsp_c        <= alu_c;
                    rsp_v        <= alu_v;
                    rsp_n        <= alu_n;
                    rsp_z        <= rsp_z & alu_z;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_imm   = '0;
        alu_src   = 1'b0;
        alu_bsel  = 1'b0;
        alu_cisel = 1'b0;
        alu_loa   = 1'b0;
        alu_logop = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = LO;
            end
            LO: begin
                alu_a     = a_q[31:0];
                alu_b     = b_q[31:0];
                alu_imm   = imm_q;
                alu_src   = (op_q == OP_ADDI32) || (op_q == OP_SUBI32);
                alu_bsel  = is_sub;
                alu_cisel = is_sub;
                alu_logop = (op_q == OP_AND32) || (op_q == OP_OR32);
                alu_loa   = (op_q == OP_OR32);
                state_nxt = is_64 ? HI : RESP;
            end
            HI: begin
                alu_a     = a_q[63:32];
                alu_b     = b_q[63:32];
                alu_bsel  = is_sub;
                alu_cisel = rsp_c;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
